// File: rtl/if_fetch_stage_if.sv
// Instruction SRAM-like port between the fetch stage (master) and instruction memory (slave).
// One request is accepted on addr_ok, and its read data returns later on data_ok.
interface if_fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time and
// buffers the returned word for decode. A flush redirects the PC and discards in-flight data.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              nextpc,
  output logic                     nextpc_en,
  output logic [31:0]              pc,
  input  logic                     flush,
  if_fetch_stage_if.master         inst,
  input  logic                     id_allowin,
  output logic                     if_to_id_valid,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_inst,
  output logic                     if_adel
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        cancel_reg, cancel_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_inst_reg, if_inst_next;
  logic        if_adel_reg, if_adel_next;
  logic        req_raw;
  logic        adv_raw;
  logic        aligned;

  assign aligned = (pc_reg[1:0] == 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= REQ;
      cancel_reg  <= 1'b0;
      pc_reg      <= RESET_PC;
      if_pc_reg   <= RESET_PC;
      if_inst_reg <= 32'd0;
      if_adel_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cancel_reg  <= cancel_next;
      pc_reg      <= pc_next;
      if_pc_reg   <= if_pc_next;
      if_inst_reg <= if_inst_next;
      if_adel_reg <= if_adel_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cancel_next  = cancel_reg;
    pc_next      = pc_reg;
    if_pc_next   = if_pc_reg;
    if_inst_next = if_inst_reg;
    if_adel_next = if_adel_reg;
    req_raw      = 1'b0;
    adv_raw      = 1'b0;

    case (state_reg)
      REQ: begin
        req_raw = aligned;
        if (flush) begin
          pc_next = nextpc;
          // A request accepted in the flush cycle still returns data that must be dropped.
          if (aligned && inst.inst_addr_ok) begin
            cancel_next = 1'b1;
            state_next  = WAIT;
          end
        end else if (!aligned) begin
          if_inst_next = 32'd0;
          if_adel_next = 1'b1;
          if_pc_next   = pc_reg;
          state_next   = HOLD;
        end else if (inst.inst_addr_ok) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (flush) begin
          pc_next = nextpc;
          if (inst.inst_data_ok) begin
            cancel_next = 1'b0;
            state_next  = REQ;
          end else begin
            cancel_next = 1'b1;
          end
        end else if (inst.inst_data_ok) begin
          if (cancel_reg) begin
            cancel_next = 1'b0;
            state_next  = REQ;
          end else begin
            if_inst_next = inst.inst_rdata;
            if_pc_next   = pc_reg;
            if_adel_next = 1'b0;
            state_next   = HOLD;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          pc_next    = nextpc;
          state_next = REQ;
        end else if (id_allowin) begin
          adv_raw    = 1'b1;
          pc_next    = nextpc;
          state_next = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase
  end

  assign inst.inst_req  = req_raw & resetn;
  assign inst.inst_addr = pc_reg;
  assign nextpc_en      = adv_raw & resetn;
  assign pc             = pc_reg;
  assign if_to_id_valid = (state_reg == HOLD);
  assign if_pc          = if_pc_reg;
  assign if_inst        = if_inst_reg;
  assign if_adel        = if_adel_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: inputs change 1ns after the rising edge,
// and outputs are checked before the next edge.
module tb_if_fetch_stage;

  logic        clk;
  logic        resetn;
  logic [31:0] nextpc;
  logic        nextpc_en;
  logic [31:0] pc;
  logic        flush;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage_if inst_bus ();

  if_fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .nextpc         (nextpc),
    .nextpc_en      (nextpc_en),
    .pc             (pc),
    .flush          (flush),
    .inst           (inst_bus),
    .id_allowin     (id_allowin),
    .if_to_id_valid (if_to_id_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_adel        (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush                 = 1'b0;
    inst_bus.inst_addr_ok = 1'b0;
    inst_bus.inst_data_ok = 1'b0;
    inst_bus.inst_rdata   = 32'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    nextpc = 32'd0;
    id_allowin = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'hBFC0_0000); end
    n_checks++;
    if (if_to_id_valid !== 1'b0 || inst_bus.inst_req !== 1'b0 || nextpc_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl got valid=%b req=%b en=%b exp 0 0 0", if_to_id_valid, inst_bus.inst_req, nextpc_en);
    end
    n_checks++;
    if (if_pc !== 32'hBFC0_0000 || if_inst !== 32'd0 || if_adel !== 1'b0) begin
      n_fail++; $display("FAIL reset_if got if_pc=%h inst=%h adel=%b", if_pc, if_inst, if_adel);
    end
    resetn = 1'b1;
    #1;
    $display("reset: pc=%h req=%b", pc, inst_bus.inst_req);
  endtask

  // One complete zero-wait fetch; also checks that nextpc_en is high only on the fire cycle.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] npc);
    id_allowin = 1'b1;
    idle_inputs();
    #1;
    n_checks++;
    if (inst_bus.inst_req !== 1'b1 || inst_bus.inst_addr !== addr || nextpc_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_req got req=%b addr=%h en=%b exp 1 %h 0", inst_bus.inst_req, inst_bus.inst_addr, nextpc_en, addr);
    end
    inst_bus.inst_addr_ok = 1'b1;
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    inst_bus.inst_data_ok = 1'b1;
    inst_bus.inst_rdata   = data;
    #1;
    n_checks++;
    if (inst_bus.inst_req !== 1'b0 || nextpc_en !== 1'b0 || if_to_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_wait got req=%b en=%b valid=%b exp 0 0 0", inst_bus.inst_req, nextpc_en, if_to_id_valid);
    end
    tick();
    inst_bus.inst_data_ok = 1'b0;
    nextpc = npc;
    #1;
    n_checks++;
    if (if_to_id_valid !== 1'b1 || if_pc !== addr || if_inst !== data || if_adel !== 1'b0 || nextpc_en !== 1'b1) begin
      n_fail++; $display("FAIL fetch_hold got valid=%b pc=%h inst=%h adel=%b en=%b exp 1 %h %h 0 1",
                         if_to_id_valid, if_pc, if_inst, if_adel, nextpc_en, addr, data);
    end
    tick();
    $display("fetch: addr=%h inst=%h next=%h", addr, data, pc);
  endtask

  task automatic test_sequential();
    fetch_one(32'hBFC0_0000, 32'hC0DE_0000, 32'hBFC0_0004);
    fetch_one(32'hBFC0_0004, 32'hC0DE_0001, 32'hBFC0_0008);
    fetch_one(32'hBFC0_0008, 32'hC0DE_0002, 32'hBFC0_000C);
    n_checks++;
    if (pc !== 32'hBFC0_000C || if_to_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL seq_end got pc=%h valid=%b exp bfc0000c 0", pc, if_to_id_valid);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    id_allowin = 1'b0;
    idle_inputs();
    inst_bus.inst_addr_ok = 1'b1;
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (inst_bus.inst_req !== 1'b0 || if_to_id_valid !== 1'b0 || pc !== 32'hBFC0_000C) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_wait got bad_cycles=%0d exp 0", bad); end
    inst_bus.inst_data_ok = 1'b1;
    inst_bus.inst_rdata   = 32'hDEAD_BEEF;
    tick();
    inst_bus.inst_data_ok = 1'b0;
    nextpc = 32'hBFC0_0010;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (if_to_id_valid !== 1'b1 || if_inst !== 32'hDEAD_BEEF || if_pc !== 32'hBFC0_000C ||
          inst_bus.inst_req !== 1'b0 || nextpc_en !== 1'b0 || pc !== 32'hBFC0_000C) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_hold got bad_cycles=%0d exp 0", bad); end
    id_allowin = 1'b1;
    #1;
    n_checks++;
    if (nextpc_en !== 1'b1) begin n_fail++; $display("FAIL stall_fire got en=%b exp 1", nextpc_en); end
    tick();
    $display("stall: released, pc=%h", pc);
  endtask

  task automatic test_flush_wait();
    idle_inputs();
    inst_bus.inst_addr_ok = 1'b1;
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    flush  = 1'b1;
    nextpc = 32'hBFC0_0380;
    #1;
    n_checks++;
    if (nextpc_en !== 1'b0) begin n_fail++; $display("FAIL flush_wait_en got=%b exp 0", nextpc_en); end
    tick();
    flush = 1'b0;
    n_checks++;
    if (pc !== 32'hBFC0_0380 || inst_bus.inst_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_pc got pc=%h req=%b exp bfc00380 0", pc, inst_bus.inst_req);
    end
    tick();
    inst_bus.inst_data_ok = 1'b1;
    inst_bus.inst_rdata   = 32'h0000_1234;
    tick();
    inst_bus.inst_data_ok = 1'b0;
    n_checks++;
    if (if_to_id_valid !== 1'b0 || inst_bus.inst_req !== 1'b1 || inst_bus.inst_addr !== 32'hBFC0_0380) begin
      n_fail++; $display("FAIL flush_wait_drop got valid=%b req=%b addr=%h exp 0 1 bfc00380",
                         if_to_id_valid, inst_bus.inst_req, inst_bus.inst_addr);
    end
    fetch_one(32'hBFC0_0380, 32'h0380_AAAA, 32'hBFC0_0384);
  endtask

  task automatic test_flush_data_ok();
    idle_inputs();
    inst_bus.inst_addr_ok = 1'b1;
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    inst_bus.inst_data_ok = 1'b1;
    inst_bus.inst_rdata   = 32'h0000_5555;
    flush  = 1'b1;
    nextpc = 32'hBFC0_0400;
    tick();
    idle_inputs();
    n_checks++;
    if (inst_bus.inst_req !== 1'b1 || inst_bus.inst_addr !== 32'hBFC0_0400 || if_to_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_dok got req=%b addr=%h valid=%b exp 1 bfc00400 0",
                         inst_bus.inst_req, inst_bus.inst_addr, if_to_id_valid);
    end
    // The next response must be delivered, so cancel must not have been left set.
    id_allowin = 1'b0;
    inst_bus.inst_addr_ok = 1'b1;
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    inst_bus.inst_data_ok = 1'b1;
    inst_bus.inst_rdata   = 32'h0400_BBBB;
    tick();
    inst_bus.inst_data_ok = 1'b0;
    n_checks++;
    if (if_to_id_valid !== 1'b1 || if_inst !== 32'h0400_BBBB || if_pc !== 32'hBFC0_0400) begin
      n_fail++; $display("FAIL flush_dok_next got valid=%b inst=%h pc=%h exp 1 0400bbbb bfc00400",
                         if_to_id_valid, if_inst, if_pc);
    end
    $display("flush_dok: pc=%h inst=%h", if_pc, if_inst);
  endtask

  task automatic test_flush_hold();
    id_allowin = 1'b1;
    flush      = 1'b1;
    nextpc     = 32'hBFC0_0500;
    #1;
    n_checks++;
    if (nextpc_en !== 1'b0) begin n_fail++; $display("FAIL flush_hold_en got=%b exp 0", nextpc_en); end
    tick();
    flush = 1'b0;
    n_checks++;
    if (if_to_id_valid !== 1'b0 || pc !== 32'hBFC0_0500 || inst_bus.inst_addr !== 32'hBFC0_0500) begin
      n_fail++; $display("FAIL flush_hold got valid=%b pc=%h addr=%h exp 0 bfc00500 bfc00500",
                         if_to_id_valid, pc, inst_bus.inst_addr);
    end
    $display("flush_hold: pc=%h", pc);
  endtask

  task automatic test_misaligned();
    fetch_one(32'hBFC0_0500, 32'h0500_CCCC, 32'hBFC0_0002);
    id_allowin = 1'b0;
    inst_bus.inst_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (inst_bus.inst_req !== 1'b0 || pc !== 32'hBFC0_0002) begin
      n_fail++; $display("FAIL adel_req got req=%b pc=%h exp 0 bfc00002", inst_bus.inst_req, pc);
    end
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    n_checks++;
    if (if_to_id_valid !== 1'b1 || if_adel !== 1'b1 || if_inst !== 32'd0 || if_pc !== 32'hBFC0_0002) begin
      n_fail++; $display("FAIL adel_hold got valid=%b adel=%b inst=%h pc=%h exp 1 1 0 bfc00002",
                         if_to_id_valid, if_adel, if_inst, if_pc);
    end
    flush  = 1'b1;
    nextpc = 32'hBFC0_0600;
    tick();
    flush = 1'b0;
    n_checks++;
    if (pc !== 32'hBFC0_0600 || inst_bus.inst_req !== 1'b1) begin
      n_fail++; $display("FAIL adel_recover got pc=%h req=%b exp bfc00600 1", pc, inst_bus.inst_req);
    end
    $display("misaligned: adel=%b pc=%h", if_adel, pc);
  endtask

  task automatic test_reset_mid();
    inst_bus.inst_addr_ok = 1'b1;
    tick();
    inst_bus.inst_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (pc !== 32'hBFC0_0000 || inst_bus.inst_req !== 1'b0 || if_to_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got pc=%h req=%b valid=%b exp bfc00000 0 0", pc, inst_bus.inst_req, if_to_id_valid);
    end
    tick();
    resetn = 1'b1;
    #1;
    n_checks++;
    if (inst_bus.inst_req !== 1'b1 || inst_bus.inst_addr !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL reset_mid_req got req=%b addr=%h exp 1 bfc00000", inst_bus.inst_req, inst_bus.inst_addr);
    end
    $display("reset_mid: pc=%h", pc);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_data_ok();
    test_flush_hold();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
